// File: rtl/dcache_way_ram_if.sv
// Request/response bundle between the dcache control FSM (master) and the
// multi-way data/tag RAM (slave).
interface dcache_way_ram_if #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 151,
    parameter int SEG_W   = 32,
    parameter int NSEG    = (LINE_W + SEG_W - 1) / SEG_W
);
    logic                     init_busy;
    logic                     rd_en;
    logic [INDEX_W-1:0]       rd_index;
    logic                     rd_valid;
    logic [WAYS*LINE_W-1:0]   rd_data;
    logic                     wr_en;
    logic [WAYS-1:0]          wr_way;
    logic [INDEX_W-1:0]       wr_index;
    logic [NSEG-1:0]          wr_mask;
    logic [LINE_W-1:0]        wr_data;

    modport master (
        input  init_busy, rd_valid, rd_data,
        output rd_en, rd_index, wr_en, wr_way, wr_index, wr_mask, wr_data
    );

    modport slave (
        output init_busy, rd_valid, rd_data,
        input  rd_en, rd_index, wr_en, wr_way, wr_index, wr_mask, wr_data
    );
endinterface

// File: rtl/dcache_way_ram.sv
// Multi-way L1 dcache line storage: segment-masked writes, same-index read bypass,
// and a one-line-per-cycle clear sequencer that keeps every array block-RAM inferable.
module dcache_way_ram #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 151,
    parameter int SEG_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_way_ram_if.slave       bus
);
    localparam int NSEG  = (LINE_W + SEG_W - 1) / SEG_W;
    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state, state_next;
    logic [INDEX_W-1:0] count, count_next;
    logic               ready, clear_we, rd_acc, wr_acc, same_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The counter naturally ends at DEPTH-1, which is the last line cleared.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            CLEAR: begin
                count_next = count + INDEX_W'(1);
                if (count == INDEX_W'(DEPTH - 1))
                    state_next = READY;
            end
            default: begin
                state_next = READY;
            end
        endcase
    end

    assign ready         = (state == READY) && !rst;
    assign clear_we      = (state == CLEAR) && !rst;
    assign rd_acc        = ready && bus.rd_en;
    assign wr_acc        = ready && bus.wr_en;
    assign same_idx      = (bus.rd_index == bus.wr_index);
    assign bus.init_busy = rst || (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst)
            bus.rd_valid <= 1'b0;
        else
            bus.rd_valid <= rd_acc;
    end

    // One narrow RAM per (way, segment): masked writes become plain per-RAM
    // write enables, and the bypass mux sits on each RAM's output register input.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        for (genvar s = 0; s < NSEG; s++) begin : g_seg
            localparam int LO = s * SEG_W;
            localparam int SW = ((LINE_W - LO) < SEG_W) ? (LINE_W - LO) : SEG_W;

            logic [SW-1:0]      mem [DEPTH];
            logic [SW-1:0]      rq;
            logic               seg_we, wr_hit;
            logic [INDEX_W-1:0] wa;
            logic [SW-1:0]      wd;

            assign wr_hit = wr_acc && bus.wr_way[w] && bus.wr_mask[s];
            assign seg_we = clear_we || wr_hit;
            assign wa     = clear_we ? count : bus.wr_index;
            assign wd     = clear_we ? '0 : bus.wr_data[LO +: SW];

            always_ff @(posedge clk) begin
                if (seg_we)
                    mem[wa] <= wd;
            end

            always_ff @(posedge clk) begin
                if (rst)
                    rq <= '0;
                else if (rd_acc)
                    rq <= (wr_hit && same_idx) ? bus.wr_data[LO +: SW] : mem[bus.rd_index];
            end

            assign bus.rd_data[w*LINE_W + LO +: SW] = rq;
        end
    end
endmodule

// File: doc/dcache_way_ram.md
Name: dcache_way_ram

Overview:
Parametrised multi-way data/tag storage for the L1 data cache. It replaces the single-way 151-bit array with WAYS parallel arrays, and supports:
- segment-masked writes;
- same-index read-during-write bypass that merges masked segments;
- a sequential, block-RAM-friendly clear sequencer in place of a one-cycle array reset.

It sits between the dcache control FSM and the physical RAM, with one read port and one write port.

Parameters:
WAYS, 2, number of ways (≥1)
INDEX_W, 6, index width; DEPTH = 2**INDEX_W lines per way
LINE_W, 151, bits per line (tag+valid+dirty+data)
SEG_W, 32, write-mask granularity in bits; NSEG = ceil(LINE_W/SEG_W), last segment may be partial (23 bits at defaults)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
init_busy  out  1  high while clear sequence runs; all requests ignored
rd_en  in  1  read request
rd_index  in  INDEX_W  read line index
rd_valid  out  1  pulses one cycle after an accepted read
rd_data  out  WAYS*LINE_W  way w at bits [w*LINE_W +: LINE_W]
wr_en  in  1  write request
wr_way  in  WAYS  one-hot (or multi-hot) way select
wr_index  in  INDEX_W  write line index
wr_mask  in  NSEG  segment enables; bit s covers bits [s*SEG_W +: SEG_W] clipped to LINE_W
wr_data  in  LINE_W  write data

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
- Values forced while rst=1: init_busy=1, rd_valid=0, rd_data=0, clear counter=0, state=CLEAR.
- States: CLEAR, READY.
- CLEAR:
  - Each cycle writes all-zero to index=counter in every way, then counter+1.
  - On the cycle the write to DEPTH-1 occurs, the next state is READY, and init_busy drops to 0 at that edge.
  - A clear takes exactly DEPTH cycles after rst deasserts.
  - rd_en/wr_en are ignored in CLEAR: no array write, no rd_valid.
- rst asserted mid-CLEAR or in READY: restarts CLEAR at counter 0 on the next edge.
- READY read:
  - rd_en=1 samples rd_index.
  - The next cycle, rd_data = registered contents of all ways and rd_valid=1.
  - Latency 1.
- rd_data holds its last value when rd_en=0; rd_valid=0 in that case.
- READY write:
  - wr_en=1 updates each selected way at wr_index.
  - Masked segments take wr_data; unmasked segments are unchanged.
  - wr_mask=0 or wr_way=0 means no change.
- Read-during-write:
  - Same index, same cycle: rd_data for selected ways is the merged result (new masked segments, old unmasked).
  - Unselected ways return old data.
  - Different indices: independent; read returns old contents.
- Write then read of the same index in the following cycle returns the new data (array already updated).
- Segment clipping: the partial last segment writes only bits up to LINE_W-1; no out-of-range bits exist.
- Indices are always in range (DEPTH = 2**INDEX_W); no wrap logic is needed beyond the counter naturally ending at DEPTH-1.
- Storage is inferable as block RAM:
  - no asynchronous reads;
  - no whole-array reset loop;
  - the bypass merge is a register-stage mux.

Test Plan:
1. Clear timing: assert rst 1 cycle, release. Required: init_busy=1 for exactly 64 cycles (defaults). A rd_en and a wr_en issued during clear produce no rd_valid and no array change. After the clear, a read of index 63 returns 0 in both ways.
2. Masked write: write way0 idx 5 with mask=0b11111 and data=A. Then write mask=0b00010 with data=B. Required: next read of idx 5 gives way0 = A with bits[63:32] replaced by B[63:32]; way1 = 0.
3. Bypass: with idx 9 way1 = C, issue same-cycle wr_en (way1, idx 9, mask=0b10000, data=D) and rd_en idx 9. Required: next cycle rd_valid=1 and way1 = C with bits[150:128] = D[150:128]; way0 unchanged.
4. Different-index concurrency: write idx 3 and read idx 4 in the same cycle. Required: old idx 4 data is returned; a read of idx 3 in the next cycle returns the new data.
5. Reset mid-clear: assert rst at counter=30. Required: clear restarts and init_busy stays high for 64 more cycles after release. Re-run with rst asserted in READY after writes: all lines read 0 after the new clear completes.
6. Hold: rd_en=0 for 10 cycles after a read. Required: rd_data stable and rd_valid=0 throughout.
